vec_stage_sequencer: RTL and testbench

Controller that sequences one elementwise vector stage, such as ReLU, sitting between an input VecFIFO and an output VecFIFO. It tracks complete vectors resident in the input FIFO and free vector slots in the output FIFO. It issues the stage's start strobe only when both are available, then follows the stage's chunk requests and completion flag to retire the vector. It gives the upstream writer and the downstream reader occupancy flags, so producer, stage and consumer are sequenced without free-running enables.

---
 rtl/vec_stage_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vec_stage_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_stage_sequencer.sv
// rtl/vec_stage_sequencer.sv - sequences one elementwise vector stage between two VecFIFOs
// Purpose: tracks complete vectors in the input FIFO and free slots in the
//   output FIFO, strobes the stage start when both exist, follows the stage's
//   chunk requests and completion, and retires the vector.
// Optional feature macro: VSEQ_WATCHDOG_EN (stall watchdog, TimeoutCycles).
// Ports:
//   clk_in        clock, rising edge
//   rst_in        asynchronous active-low reset
//   enable        gates issue of new vectors
//   in_wr_en      input FIFO write strobe mirror (one chunk per cycle)
//   in_space      input vector count below InDepth
//   stage_start   stage in_data_ready (high while in ISSUE)
//   stage_req     stage chunk request
//   stage_done    stage vector complete
//   out_rd_vec    downstream consumed one vector
//   out_vec_avail output vector count nonzero
//   busy          FSM not idle
//   err           sticky protocol error
//   vec_count     retired vector count (wraps)
module vec_stage_sequencer #(
  parameter int VecElements   = 8,
  parameter int BytesPerWrite = 2,
  parameter int WorkingRegs   = 4,
  parameter int InDepth       = 2,
  parameter int OutDepth      = 2,
  parameter int TimeoutCycles = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable,
  input  logic        in_wr_en,
  output logic        in_space,
  output logic        stage_start,
  input  logic        stage_req,
  input  logic        stage_done,
  input  logic        out_rd_vec,
  output logic        out_vec_avail,
  output logic        busy,
  output logic        err,
  output logic [15:0] vec_count
);

  localparam int Writes = VecElements / BytesPerWrite;
  localparam int Chunks = VecElements / WorkingRegs;
  localparam int WcW    = (Writes > 1) ? $clog2(Writes) : 1;
  localparam int IvW    = $clog2(InDepth + 1);
  localparam int OvW    = $clog2(OutDepth + 1);
  localparam int RcW    = $clog2(Chunks + 1);

  localparam logic [WcW-1:0] WLAST    = WcW'(Writes - 1);
  localparam logic [IvW-1:0] IN_FULL  = IvW'(InDepth);
  localparam logic [OvW-1:0] OUT_FULL = OvW'(OutDepth);
  localparam logic [RcW-1:0] R_MAX    = RcW'(Chunks);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic [WcW-1:0] r_wcnt;
  logic [IvW-1:0] r_in_vecs;
  logic [OvW-1:0] r_out_vecs;
  logic [RcW-1:0] r_rcnt;
  logic [15:0]    r_vec_count;
  logic           r_err;
  logic           r_stage_start;
  logic           r_busy;
  logic           r_in_space;
  logic           r_out_avail;

  logic           w_wr_block;
  logic           w_wr_acc;
  logic           w_wr_last;
  logic           w_rd_err;
  logic           w_rd_ok;
  logic           w_done;
  logic           w_wd_fire;
  logic           w_in_dec;
  logic [IvW-1:0] w_in_vecs_nxt;
  logic [OvW-1:0] w_out_vecs_nxt;

`ifdef VSEQ_WATCHDOG_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  localparam logic [WdW-1:0] WD_LAST = WdW'(TimeoutCycles - 1);
  logic [WdW-1:0] r_wd;
  assign w_wd_fire = ((r_state == S_ISSUE) || (r_state == S_RUN)) && (r_wd == WD_LAST);
`else
  assign w_wd_fire = 1'b0;
`endif

  // A write is refused only at a vector boundary with the FIFO full; a
  // partially written vector always has room to finish.
  assign w_wr_block = in_wr_en && (r_in_vecs == IN_FULL) && (r_wcnt == '0);
  assign w_wr_acc   = in_wr_en && !w_wr_block;
  assign w_wr_last  = w_wr_acc && (r_wcnt == WLAST);
  assign w_rd_err   = out_rd_vec && (r_out_vecs == '0);
  assign w_rd_ok    = out_rd_vec && !w_rd_err;
  assign w_done     = (r_state == S_DONE);
  assign w_in_dec   = w_done || w_wd_fire;

  // Same-edge increment and decrement cancel to the net change.
  always_comb begin
    w_in_vecs_nxt = r_in_vecs;
    if (w_wr_last && !w_in_dec)
      w_in_vecs_nxt = r_in_vecs + IvW'(1);
    else if (!w_wr_last && w_in_dec)
      w_in_vecs_nxt = r_in_vecs - IvW'(1);
  end

  always_comb begin
    w_out_vecs_nxt = r_out_vecs;
    if (w_done && !w_rd_ok)
      w_out_vecs_nxt = r_out_vecs + OvW'(1);
    else if (!w_done && w_rd_ok)
      w_out_vecs_nxt = r_out_vecs - OvW'(1);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_in_vecs     <= '0;
      r_out_vecs    <= '0;
      r_rcnt        <= '0;
      r_vec_count   <= '0;
      r_err         <= 1'b0;
      r_stage_start <= 1'b0;
      r_busy        <= 1'b0;
      r_in_space    <= 1'b1;
      r_out_avail   <= 1'b0;
`ifdef VSEQ_WATCHDOG_EN
      r_wd          <= '0;
`endif
    end else begin
      if (w_wr_acc)
        r_wcnt <= w_wr_last ? '0 : r_wcnt + WcW'(1);
      r_in_vecs   <= w_in_vecs_nxt;
      r_in_space  <= (w_in_vecs_nxt < IN_FULL);
      r_out_vecs  <= w_out_vecs_nxt;
      r_out_avail <= (w_out_vecs_nxt != '0);
      if (w_wr_block || w_rd_err)
        r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (enable && (r_in_vecs != '0) && (r_out_vecs < OUT_FULL)) begin
            r_state       <= S_ISSUE;
            r_rcnt        <= '0;
            r_stage_start <= 1'b1;
            r_busy        <= 1'b1;
`ifdef VSEQ_WATCHDOG_EN
            r_wd          <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (stage_req) begin
            r_rcnt        <= RcW'(1);
            r_state       <= S_RUN;
            r_stage_start <= 1'b0;
          end else if (stage_done) begin
            // Completion without any chunk request is a stage protocol error.
            r_state       <= S_DONE;
            r_stage_start <= 1'b0;
            r_err         <= 1'b1;
          end
        end
        S_RUN: begin
          if (stage_req) begin
            if (r_rcnt == R_MAX)
              r_err <= 1'b1;
            else
              r_rcnt <= r_rcnt + RcW'(1);
          end
          if (stage_done)
            r_state <= S_DONE;
        end
        default: begin
          r_vec_count <= r_vec_count + 16'd1;
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
        end
      endcase

`ifdef VSEQ_WATCHDOG_EN
      // Placed after the case so a timeout overrides any stage transition.
      if ((r_state == S_ISSUE) || (r_state == S_RUN)) begin
        if (w_wd_fire) begin
          r_state       <= S_IDLE;
          r_stage_start <= 1'b0;
          r_busy        <= 1'b0;
          r_err         <= 1'b1;
        end else begin
          r_wd <= r_wd + WdW'(1);
        end
      end
`endif
    end
  end

  assign in_space      = r_in_space;
  assign stage_start   = r_stage_start;
  assign out_vec_avail = r_out_avail;
  assign busy          = r_busy;
  assign err           = r_err;
  assign vec_count     = r_vec_count;

endmodule

// File: tb/tb_vec_stage_sequencer.sv
// tb/tb_vec_stage_sequencer.sv - directed self-checking bench for vec_stage_sequencer
module tb_vec_stage_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable;
  logic        in_wr_en;
  logic        in_space;
  logic        stage_start;
  logic        stage_req;
  logic        stage_done;
  logic        out_rd_vec;
  logic        out_vec_avail;
  logic        busy;
  logic        err;
  logic [15:0] vec_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_vc = 0;

  vec_stage_sequencer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .enable        (enable),
    .in_wr_en      (in_wr_en),
    .in_space      (in_space),
    .stage_start   (stage_start),
    .stage_req     (stage_req),
    .stage_done    (stage_done),
    .out_rd_vec    (out_rd_vec),
    .out_vec_avail (out_vec_avail),
    .busy          (busy),
    .err           (err),
    .vec_count     (vec_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in     = 1'b0;
    in_wr_en   = 1'b0;
    stage_req  = 1'b0;
    stage_done = 1'b0;
    out_rd_vec = 1'b0;
    repeat (2) step();
    rst_in = 1'b1;
    step();
  endtask

  task automatic write_chunks(input int n);
    for (int i = 0; i < n; i++) begin
      in_wr_en = 1'b1;
      step();
    end
    in_wr_en = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (stage_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("start_seen", {31'd0, stage_start}, 32'd1);
  endtask

  // From ISSUE: two chunk requests, then completion; leaves the FSM in DONE.
  task automatic stage_run_to_done();
    stage_req = 1'b1;
    repeat (2) step();
    stage_req  = 1'b0;
    stage_done = 1'b1;
    step();
    stage_done = 1'b0;
  endtask

  task automatic process_vec();
    wait_start();
    stage_run_to_done();
    check("done_busy", {31'd0, busy}, 32'd1);
    step();
    exp_vc++;
    check("vec_count", {16'd0, vec_count}, exp_vc);
  endtask

  task automatic drain(input int n);
    out_rd_vec = 1'b1;
    repeat (n) step();
    out_rd_vec = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    enable = 1'b1;
    do_reset();
    check("rst_stage_start", {31'd0, stage_start}, 32'd0);
    check("rst_in_space", {31'd0, in_space}, 32'd1);
    check("rst_out_avail", {31'd0, out_vec_avail}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_vec_count", {16'd0, vec_count}, 32'd0);

    // Read from an empty output FIFO.
    drain(1);
    check("underflow_err", {31'd0, err}, 32'd1);
    check("underflow_out_vecs", 32'(dut.r_out_vecs), 32'd0);
    check("underflow_avail", {31'd0, out_vec_avail}, 32'd0);
    do_reset();
    check("rerst_err", {31'd0, err}, 32'd0);

    // Single vector end to end with latency check.
    write_chunks(4);
    check("t1_in_vecs", 32'(dut.r_in_vecs), 32'd1);
    check("t1_start_early", {31'd0, stage_start}, 32'd0);
    step();
    check("t1_start_latency", {31'd0, stage_start}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    stage_run_to_done();
    check("t1_done_busy", {31'd0, busy}, 32'd1);
    step();
    exp_vc = 1;
    check("t1_vec_count", {16'd0, vec_count}, 32'd1);
    check("t1_out_avail", {31'd0, out_vec_avail}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_in_vecs_after", 32'(dut.r_in_vecs), 32'd0);

    // Output-full back-pressure.
    drain(1);
    write_chunks(8);
    check("t2_in_vecs", 32'(dut.r_in_vecs), 32'd2);
    check("t2_in_space", {31'd0, in_space}, 32'd0);
    process_vec();
    process_vec();
    check("t2_out_vecs", 32'(dut.r_out_vecs), 32'd2);
    write_chunks(4);
    repeat (3) step();
    check("t2_full_hold_start", {31'd0, stage_start}, 32'd0);
    check("t2_full_hold_busy", {31'd0, busy}, 32'd0);
    drain(1);
    step();
    check("t2_reissue", {31'd0, stage_start}, 32'd1);
    process_vec();
    check("t2_err", {31'd0, err}, 32'd0);

    // Overflowing write at a vector boundary.
    write_chunks(8);
    check("t3_in_space", {31'd0, in_space}, 32'd0);
    write_chunks(1);
    check("t3_overflow_err", {31'd0, err}, 32'd1);
    check("t3_in_vecs", 32'(dut.r_in_vecs), 32'd2);
    check("t3_wcnt", 32'(dut.r_wcnt), 32'd0);
    drain(2);
    process_vec();
    process_vec();
    drain(2);
    check("t3_out_avail", {31'd0, out_vec_avail}, 32'd0);

    // Completing write on the DONE edge.
    write_chunks(4);
    write_chunks(3);
    wait_start();
    stage_run_to_done();
    write_chunks(1);
    exp_vc++;
    check("t4_same_edge_in", 32'(dut.r_in_vecs), 32'd1);
    check("t4_out_vecs", 32'(dut.r_out_vecs), 32'd1);
    check("t4_vec_count", {16'd0, vec_count}, exp_vc);
    // Downstream read on the DONE edge.
    wait_start();
    stage_run_to_done();
    drain(1);
    exp_vc++;
    check("t4_same_edge_out", 32'(dut.r_out_vecs), 32'd1);
    check("t4_in_vecs_end", 32'(dut.r_in_vecs), 32'd0);
    check("t4_vec_count2", {16'd0, vec_count}, 32'd8);

    // Asynchronous reset in RUN.
    write_chunks(4);
    wait_start();
    stage_req = 1'b1;
    step();
    stage_req = 1'b0;
    check("t5_running", {31'd0, busy}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_out_avail", {31'd0, out_vec_avail}, 32'd0);
    check("t5_rst_vec_count", {16'd0, vec_count}, 32'd0);
    check("t5_rst_in_space", {31'd0, in_space}, 32'd1);
    check("t5_rst_start", {31'd0, stage_start}, 32'd0);
    check("t5_rst_err", {31'd0, err}, 32'd0);
    step();
    rst_in = 1'b1;
    repeat (3) step();
    check("t5_post_start", {31'd0, stage_start}, 32'd0);
    check("t5_post_busy", {31'd0, busy}, 32'd0);
    check("t5_post_in_vecs", 32'(dut.r_in_vecs), 32'd0);

    // Stalled stage.
    write_chunks(4);
    wait_start();
`ifdef VSEQ_WATCHDOG_EN
    repeat (63) step();
    check("t6_wd_before", {31'd0, busy}, 32'd1);
    step();
    check("t6_wd_busy", {31'd0, busy}, 32'd0);
    check("t6_wd_err", {31'd0, err}, 32'd1);
    check("t6_wd_in_vecs", 32'(dut.r_in_vecs), 32'd0);
    check("t6_wd_vec_count", {16'd0, vec_count}, 32'd0);
    check("t6_wd_start", {31'd0, stage_start}, 32'd0);
`else
    repeat (80) step();
    check("t6_stall_busy", {31'd0, busy}, 32'd1);
    check("t6_stall_start", {31'd0, stage_start}, 32'd1);
    check("t6_stall_err", {31'd0, err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
